// File: rtl/wrr_lock_arbiter.sv
// wrr_lock_arbiter: weighted round-robin arbiter with packet lock.
// A winner holds the grant from its first acknowledged flit through the tail
// flit, and keeps priority for up to weight[i] consecutive packets before
// priority rotates to the next requester after it.
module wrr_lock_arbiter #(
  parameter int ARBITER_WIDTH = 8,
  parameter int WEIGHT_WIDTH  = 4
) (
  input  logic                                  clk,
  input  logic                                  reset,
  input  logic [ARBITER_WIDTH-1:0]              request,
  input  logic [ARBITER_WIDTH*WEIGHT_WIDTH-1:0] weight,
  input  logic                                  grant_ack,
  input  logic                                  last,
  output logic [ARBITER_WIDTH-1:0]              grant,
  output logic [$clog2(ARBITER_WIDTH)-1:0]      grant_bin,
  output logic                                  any_grant,
  output logic                                  locked
);

  localparam int BIN_WIDTH = $clog2(ARBITER_WIDTH);

  // Arbitration state.
  logic [BIN_WIDTH-1:0]    ptr;   // last acknowledged winner
  logic                    turn;  // ptr owns the current weighted turn
  logic                    pkt;   // a packet is in progress for ptr
  logic [WEIGHT_WIDTH-1:0] cnt;   // packets completed by ptr this turn

  logic [ARBITER_WIDTH-1:0] owner_onehot;
  logic [ARBITER_WIDTH-1:0] rr_grant;
  logic                     ack_ok;
  logic [WEIGHT_WIDTH-1:0]  w_raw;
  logic [WEIGHT_WIDTH:0]    w_eff;
  logic [WEIGHT_WIDTH:0]    base;
  logic [WEIGHT_WIDTH:0]    c_next;
  logic                     rotate;

  assign owner_onehot = {{(ARBITER_WIDTH-1){1'b0}}, 1'b1} << ptr;

  // Round-robin search starting just after ptr; ptr itself is checked last.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path
    // leaves it unassigned, which would otherwise infer a latch.
    int   idx;
    logic found;
    rr_grant = '0;
    found    = 1'b0;
    idx      = 0;
    for (int k = 1; k <= ARBITER_WIDTH; k++) begin
      idx = (int'(ptr) + k) % ARBITER_WIDTH;
      if (!found && request[idx]) begin
        rr_grant[idx] = 1'b1;
        found         = 1'b1;
      end
    end
  end

  // Grant selection: packet lock, then retained turn, then round-robin.
  always_comb begin
    grant = '0;
    if (pkt) begin
      grant = owner_onehot & request;
    end else if (turn && request[ptr]) begin
      grant = owner_onehot;
    end else begin
      grant = rr_grant;
    end
  end

  // Binary encoding of the one-hot grant; zero when nothing is granted.
  always_comb begin
    grant_bin = '0;
    for (int i = 0; i < ARBITER_WIDTH; i++) begin
      if (grant[i]) grant_bin = BIN_WIDTH'(i);
    end
  end

  assign any_grant = |grant;
  assign locked    = pkt;
  assign ack_ok    = grant_ack && any_grant;

  // Turn accounting for the current winner: a weight of 0 counts as 1.
  always_comb begin
    w_raw  = weight[int'(grant_bin)*WEIGHT_WIDTH +: WEIGHT_WIDTH];
    w_eff  = (w_raw == '0) ? (WEIGHT_WIDTH+1)'(1) : {1'b0, w_raw};
    base   = (turn && (grant_bin == ptr)) ? {1'b0, cnt} : '0;
    c_next = base + {{WEIGHT_WIDTH{1'b0}}, last};
    rotate = last && (c_next >= w_eff);
  end

  // State update on an honoured ack; reset overrides any simultaneous ack.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    if (reset) begin
      ptr  <= BIN_WIDTH'(ARBITER_WIDTH-1);
      turn <= 1'b0;
      pkt  <= 1'b0;
      cnt  <= '0;
    end else if (ack_ok) begin
      ptr <= grant_bin;
      pkt <= ~last;
      if (rotate) begin
        turn <= 1'b0;
        cnt  <= '0;
      end else begin
        turn <= 1'b1;
        cnt  <= c_next[WEIGHT_WIDTH-1:0];
      end
    end
  end

endmodule

// File: tb/tb_wrr_lock_arbiter.sv
// Directed self-checking bench for wrr_lock_arbiter.
// Inputs change on the falling edge; outputs are checked shortly after,
// well away from the rising edge where state updates.
module tb_wrr_lock_arbiter;

  localparam int N  = 8;
  localparam int WW = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic [N-1:0]  request;
  logic [N*WW-1:0] weight;
  logic          grant_ack;
  logic          last;
  logic [N-1:0]  grant;
  logic [2:0]    grant_bin;
  logic          any_grant;
  logic          locked;

  int total = 0;
  int bad   = 0;

  wrr_lock_arbiter #(.ARBITER_WIDTH(N), .WEIGHT_WIDTH(WW)) dut (
    .clk       (clk),
    .reset     (reset),
    .request   (request),
    .weight    (weight),
    .grant_ack (grant_ack),
    .last      (last),
    .grant     (grant),
    .grant_bin (grant_bin),
    .any_grant (any_grant),
    .locked    (locked)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Check all outputs against an expected winner (or no grant).
  task automatic expect_out(input string tag, input int exp_bin, input bit exp_any, input bit exp_lock);
    logic [N-1:0] eg;
    eg = exp_any ? (N'(1) << exp_bin) : '0;
    check({tag, ".grant"},     32'(grant),     32'(eg));
    check({tag, ".grant_bin"}, 32'(grant_bin), exp_any ? 32'(exp_bin) : 32'd0);
    check({tag, ".any"},       32'(any_grant), 32'(exp_any));
    check({tag, ".locked"},    32'(locked),    32'(exp_lock));
  endtask

  // Apply ack/last across one rising edge, return after the next falling edge.
  task automatic cycle(input bit ack, input bit lst);
    grant_ack = ack;
    last      = lst;
    @(posedge clk);
    @(negedge clk);
    grant_ack = 1'b0;
    last      = 1'b0;
  endtask

  task automatic do_reset();
    reset     = 1'b1;
    grant_ack = 1'b0;
    last      = 1'b0;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    int eq_seq [9] = '{0, 1, 2, 3, 4, 5, 6, 7, 0};
    int wt_seq [8] = '{0, 2, 2, 2, 0, 2, 2, 2};
    int z_seq  [4] = '{0, 1, 0, 1};

    request = '0;
    weight  = 32'h1111_1111;
    do_reset();

    // Reset state: nothing requested, nothing granted.
    #1 expect_out("rst_idle", 0, 1'b0, 1'b0);
    request = 8'hFF;
    #1 expect_out("rst_ff", 0, 1'b1, 1'b0);

    // Equal weights: plain round-robin, single-flit packets never lock.
    for (int i = 0; i < 9; i++) begin
      #1 expect_out($sformatf("eq%0d", i), eq_seq[i], 1'b1, 1'b0);
      cycle(1'b1, 1'b1);
    end

    // Weighted turn: requester 2 keeps priority for three packets.
    do_reset();
    weight  = 32'h1111_1311;
    request = 8'h05;
    for (int i = 0; i < 8; i++) begin
      #1 expect_out($sformatf("wt%0d", i), wt_seq[i], 1'b1, 1'b0);
      cycle(1'b1, 1'b1);
    end

    // Owner leaves mid-turn: another requester wins and 2 restarts a full turn.
    do_reset();
    request = 8'h05;
    #1 expect_out("lv0", 0, 1'b1, 1'b0);
    cycle(1'b1, 1'b1);
    #1 expect_out("lv1", 2, 1'b1, 1'b0);
    cycle(1'b1, 1'b1);                    // 2 has completed one of three
    request = 8'h01;
    #1 expect_out("lv2", 0, 1'b1, 1'b0);
    cycle(1'b1, 1'b1);
    request = 8'h05;
    for (int i = 0; i < 3; i++) begin
      #1 expect_out($sformatf("lv_turn%0d", i), 2, 1'b1, 1'b0);
      cycle(1'b1, 1'b1);
    end
    #1 expect_out("lv_rot", 0, 1'b1, 1'b0);

    // Packet lock: four-flit packet from requester 0.
    do_reset();
    weight  = 32'h1111_1111;
    request = 8'h03;
    #1 expect_out("pk1", 0, 1'b1, 1'b0);
    cycle(1'b1, 1'b0);
    #1 expect_out("pk2", 0, 1'b1, 1'b1);
    cycle(1'b1, 1'b0);
    #1 expect_out("pk3", 0, 1'b1, 1'b1);
    cycle(1'b1, 1'b0);
    #1 expect_out("pk4", 0, 1'b1, 1'b1);
    cycle(1'b0, 1'b1);                    // last without ack is ignored
    #1 expect_out("pk4b", 0, 1'b1, 1'b1);
    cycle(1'b1, 1'b1);
    #1 expect_out("pk5", 1, 1'b1, 1'b0);

    // Owner drop mid-packet: no grant, lock held, acks ignored.
    do_reset();
    request = 8'h03;
    #1 expect_out("od0", 0, 1'b1, 1'b0);
    cycle(1'b1, 1'b0);
    request = 8'h02;
    #1 expect_out("od1", 0, 1'b0, 1'b1);
    cycle(1'b1, 1'b1);
    #1 expect_out("od2", 0, 1'b0, 1'b1);
    request = 8'h03;
    #1 expect_out("od3", 0, 1'b1, 1'b1);
    cycle(1'b1, 1'b1);
    #1 expect_out("od4", 1, 1'b1, 1'b0);

    // Reset mid-packet with ptr=5, together with an ack.
    do_reset();
    request = 8'h20;
    #1 expect_out("rm0", 5, 1'b1, 1'b0);
    cycle(1'b1, 1'b0);
    #1 expect_out("rm1", 5, 1'b1, 1'b1);
    reset = 1'b1;
    cycle(1'b1, 1'b0);
    reset   = 1'b0;
    request = 8'hFF;
    #1 expect_out("rm2", 0, 1'b1, 1'b0);

    // Weight 0 behaves as weight 1.
    do_reset();
    weight  = 32'h1111_1101;
    request = 8'h03;
    for (int i = 0; i < 4; i++) begin
      #1 expect_out($sformatf("w0_%0d", i), z_seq[i], 1'b1, 1'b0);
      cycle(1'b1, 1'b1);
    end

    // Ack with no request changes nothing.
    do_reset();
    weight  = 32'h1111_1111;
    request = 8'h00;
    #1 expect_out("nr0", 0, 1'b0, 1'b0);
    cycle(1'b1, 1'b0);
    cycle(1'b1, 1'b1);
    #1 expect_out("nr1", 0, 1'b0, 1'b0);
    request = 8'hFF;
    #1 expect_out("nr2", 0, 1'b1, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/wrr_lock_arbiter.md
# wrr_lock_arbiter

Weighted round-robin arbiter with packet lock, generalising the NoC round-robin arbiters to per-requester weights and multi-flit ownership. A winner keeps the grant for a whole packet, from first acknowledged flit through the flit flagged `last`. It then keeps priority for up to `weight[i]` consecutive packets before priority rotates. It sits in front of router output ports and shared NI resources where a switch must not interleave flits of different packets.

## Interface
- `ARBITER_WIDTH`, 8: number of requesters; must be ≥ 2.
- `WEIGHT_WIDTH`, 4: bits per weight field and width of the packet counter.
- `BIN_WIDTH`, log2(ARBITER_WIDTH) (ceiling): width of `grant_bin`; localparam.

Ports:
- `clk` in 1: single clock, rising edge.
- `reset` in 1: synchronous, active-high.
- `request` in ARBITER_WIDTH: request vector, one bit per requester.
- `weight` in ARBITER_WIDTH*WEIGHT_WIDTH: packets per turn, field i = bits [(i+1)*WEIGHT_WIDTH-1 : i*WEIGHT_WIDTH]. A value of 0 is treated as 1. Quasi-static.
- `grant_ack` in 1: the current grant is consumed this cycle (one flit sent).
- `last` in 1: qualifies `grant_ack`; the consumed flit is the packet tail.
- `grant` out ARBITER_WIDTH: one-hot grant, or all zeros.
- `grant_bin` out BIN_WIDTH: binary index of `grant`; 0 when `grant` is zero.
- `any_grant` out 1: equals |grant.
- `locked` out 1: a packet is in progress (`pkt` register).

## Operation
- State registers:
  - `ptr` (BIN_WIDTH): index of the last acknowledged winner.
  - `turn`: `ptr` owns the current weighted turn.
  - `pkt`: mid-packet lock.
  - `cnt` (WEIGHT_WIDTH): packets completed by `ptr` in the current turn.
- Reset values: ptr=ARBITER_WIDTH-1, turn=0, pkt=0, cnt=0. After reset, requester 0 has the highest priority.
- Grant selection is combinational, evaluated in priority order:
  - If pkt=1: grant = onehot(ptr) & request. No other requester can win, even if the owner drops its request.
  - Else, if turn=1 and request[ptr]=1: grant = onehot(ptr).
  - Else: round-robin search starting at index ptr+1 (mod ARBITER_WIDTH) and wrapping around. `ptr` itself has the lowest priority.
- `grant_ack` is honoured only when any_grant=1. An ack while grant=0 changes no state.
- On an honoured ack, with winner w = grant_bin and weff = max(weight[w], 1):
  - base = cnt if (turn=1 and w==ptr), else 0.
  - c = base + last.
  - ptr ← w; pkt ← ~last.
  - If last=1 and c ≥ weff: turn ← 0, cnt ← 0. Priority rotates past w.
  - Otherwise: turn ← 1, cnt ← c.
- During the retained turn, if the owner stops requesting, the round-robin search from ptr+1 picks another requester. Acking that winner starts a new turn for it with base 0.
- `last` without `grant_ack` is ignored.
- A single-flit packet is an ack with last=1 on its first flit. The lock is never set for it.
- `cnt` never exceeds weff, so there is no wrap-around. weight = 2^WEIGHT_WIDTH-1 is legal.

## Timing
- Latency from `request` to `grant`/`grant_bin`/`any_grant` is zero cycles (combinational).
- `grant_ack` and `last` take effect on the next rising clock edge. The new grant is visible in the following cycle.
- One flit per cycle is possible: ack and last asserted every cycle yields one packet per cycle.
- Output values after reset:
  - `locked`=0.
  - `grant` is a function of `request` only, with index 0 highest priority.
  - All outputs are zero while request=0.
- Reset asserted mid-packet or mid-turn clears pkt, turn, cnt and ptr on that edge, overriding any simultaneous ack. The in-progress packet is abandoned.
- A requester must hold its request until its tail is acked. If it drops the request, grant=0 and locked=1 until it returns.

## Test plan
- Equal weights: all weights 1, request=8'hFF, ack+last every cycle after reset → grant_bin sequence 0,1,2,3,4,5,6,7,0.
- Weighted turn: weight[2]=3, others 1, request=8'h05, ack+last every cycle → grant_bin sequence 0,2,2,2,0,2,2,2.
- Packet lock: request=8'h03, ack with last=0 for 3 cycles, then ack+last → grant=8'h01 for 4 cycles and locked=1 in cycles 2–4. The next cycle gives grant=8'h02, locked=0.
- Owner drop: owner 0 mid-packet, request changes 8'h03→8'h02 → grant=0, any_grant=0, locked=1, and acks are ignored. When request returns to 8'h03, grant=8'h01 again.
- Reset mid-packet: locked=1 with ptr=5, pulse reset together with grant_ack → next cycle locked=0, and request=8'hFF gives grant_bin=0.
- Edge cases: weight[1]=0 gives the same sequence as weight 1. Ack with request=0 leaves state unchanged, and a later request=8'hFF grants index 0.
